saber_config_bank: RTL
======================

// Module: saber_config_bank
// PURPOSE
//  Parametrised bank of CH lightsaber blade-configuration registers, each W bits wide.
//  Writes and steps land in staging registers; an arm/commit handshake copies all staging
//  registers to the active outputs atomically. Sits between the control decoder and the
//  blade drivers; active outputs change only on an accepted commit.
// PARAMETERS
//  CH          4   number of configuration channels (>=1)
//  W           2   bits per channel (>=1)
//  INVERT      1   1: staged value = ~wr_data (blade-code encoding, 00->11, 01->10 ...); 0: as-is
//  ARM_TIMEOUT 8   cycles an arm remains valid without a commit (>=1)
//  AW          $clog2(CH) (min 1)  channel address width, derived
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  rst        in   1     synchronous, active-high reset
//  wr_en      in   1     write wr_data into staging[wr_addr]
//  wr_addr    in   AW    channel for write
//  wr_data    in   W     raw config value (encoded per INVERT)
//  step_en    in   1     increment staging[step_addr] mod 2^W
//  step_addr  in   AW    channel for step
//  arm        in   1     request arm for commit
//  commit     in   1     apply staging to active (accepted only when ARMED)
//  lock       in   1     level; 1 freezes staging, arm and commit
//  cfg_out    out  CH*W  active config; channel i at [i*W +: W]
//  pending    out  1     staging differs from active by at least one write/step since last commit
//  armed      out  1     FSM is in ARMED
//  ack        out  1     1-cycle pulse: commit accepted
//  timeout    out  1     1-cycle pulse: arm expired
//  err        out  1     1-cycle pulse: illegal request (see below)
// BEHAVIOUR
//  Reset (rst=1 at edge): staging and cfg_out = all INVERT?1:0 per bit (encoded zero);
//   pending=0, armed=0, ack=0, timeout=0, err=0, FSM=IDLE, timer=0. Reset overrides all inputs.
//  Staging update (lock=0): wr_en -> staging[wr_addr] = enc(wr_data) next edge.
//   step_en -> staging[step_addr] = staging+1, wraps 2^W-1 -> 0 (on stored value).
//   wr_en and step_en to same addr same cycle: write wins, step dropped. Different addr: both.
//   Address >= CH: operation ignored, err pulses next cycle.
//  pending: set on any accepted write/step; cleared on accepted commit; set-wins if a
//   write/step and commit coincide (commit still copies the new value, so cfg_out reflects it).
//  FSM: IDLE -arm&!lock-> ARMED, timer=ARM_TIMEOUT.
//   ARMED: commit&!lock -> cfg_out <= staging (including same-cycle write/step), ack=1, IDLE.
//          else timer decrements; timer reaching 0 -> IDLE, timeout=1.
//          arm while ARMED reloads timer (no err).
//  Commit in IDLE, or any arm/commit/wr/step while lock=1: ignored, err=1 next cycle.
//   lock asserted while ARMED: FSM -> IDLE next edge, no timeout pulse.
//  Latency: cfg_out, ack, pending, armed all update 1 cycle after the sampling edge.
//  Commit and arm same cycle in ARMED: commit taken, arm ignored. In IDLE: arm taken, err for commit.
//  cfg_out holds between commits regardless of staging activity; no combinational input->output path.
// TESTING
//  1 reset, CH=4 W=2 INVERT=1 -> cfg_out=8'hFF, pending=0, armed=0.
//  2 wr ch2 data 2'b01; arm; commit next cycle -> ack 1 cycle, cfg_out[5:4]=2'b10, pending=0.
//  3 step ch1 from 2'b11 twice -> staging 00 then 01 (wrap); commit shows 01 only after ack.
//  4 arm, no commit for 8 cycles -> timeout pulse on cycle 8, armed=0; later commit -> err, cfg_out unchanged.
//  5 lock=1: wr ch0, arm, commit -> err each, staging/cfg_out unchanged; lock mid-ARMED -> IDLE, no timeout.
//  6 wr and step ch3 same cycle plus commit while ARMED -> write value committed, pending=1 not cleared;
//    rst mid-ARMED -> all outputs back to reset values next edge.

Source files
------------

// File: rtl/saber_config_bank.sv
// saber_config_bank - staged blade-configuration registers with arm/commit atomic apply
// Writes/steps land in staging; an accepted commit copies all staging to cfg_out at once.
module saber_config_bank #(
  parameter int CH          = 4,
  parameter int W           = 2,
  parameter int INVERT      = 1,
  parameter int ARM_TIMEOUT = 8,
  parameter int AW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          step_en,
  input  logic [AW-1:0] step_addr,
  input  logic          arm,
  input  logic          commit,
  input  logic          lock,
  output logic [CH*W-1:0] cfg_out,
  output logic          pending,
  output logic          armed,
  output logic          ack,
  output logic          timeout,
  output logic          err
);

  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [W-1:0]  ZERO_CODE = (INVERT != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [TW-1:0] TMAX      = TW'(ARM_TIMEOUT);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_ARMED  = 1'b1;

  logic [W-1:0]  staging     [CH];
  logic [W-1:0]  staging_nxt [CH];
  logic [0:0]    state;
  logic [TW-1:0] timer;

  logic wr_in, step_in, wr_ok, step_ok;
  logic lock_bad, addr_bad, idle_commit, do_commit, touched;
  logic [W-1:0] enc_data;

  assign wr_in    = {{(32-AW){1'b0}}, wr_addr}   < 32'(CH);
  assign step_in  = {{(32-AW){1'b0}}, step_addr} < 32'(CH);
  assign enc_data = (INVERT != 0) ? ~wr_data : wr_data;

  always_comb begin
    lock_bad    = lock & (wr_en | step_en | arm | commit);
    addr_bad    = !lock && ((wr_en && !wr_in) || (step_en && !step_in));
    wr_ok       = !lock && wr_en && wr_in;
    // a write to the same channel wins over a step in the same cycle
    step_ok     = !lock && step_en && step_in && !(wr_ok && (step_addr == wr_addr));
    touched     = wr_ok | step_ok;
    do_commit   = (state == ST_ARMED) && commit && !lock;
    idle_commit = (state == ST_IDLE) && commit && !lock;
    for (int i = 0; i < CH; i++) begin
      staging_nxt[i] = staging[i];
      if (step_ok && (step_addr == AW'(i))) staging_nxt[i] = staging[i] + W'(1);
      if (wr_ok && (wr_addr == AW'(i)))     staging_nxt[i] = enc_data;
    end
  end

  assign armed = (state == ST_ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        staging[i]         <= ZERO_CODE;
        cfg_out[i*W +: W]  <= ZERO_CODE;
      end
      pending <= 1'b0;
      ack     <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
      state   <= ST_IDLE;
      timer   <= '0;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      err     <= lock_bad | addr_bad | idle_commit;
      for (int i = 0; i < CH; i++) begin
        staging[i] <= staging_nxt[i];
        if (do_commit) cfg_out[i*W +: W] <= staging_nxt[i];
      end
      // set-wins: a write/step coinciding with commit leaves pending high
      if (do_commit)    pending <= touched;
      else if (touched) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (arm && !lock) begin
            state <= ST_ARMED;
            timer <= TMAX;
          end
        end
        default: begin
          if (lock) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (commit) begin
            ack   <= 1'b1;
            state <= ST_IDLE;
            timer <= '0;
          end else if (arm) begin
            timer <= TMAX;
          end else if (timer == TW'(1)) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
            timer   <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end

endmodule
